// File: rtl/rr_mux_4_feed_if.sv
// Handshake and data bundle between four requesters, the arbiter/capture stage
// and its downstream consumer.
interface rr_mux_4_feed_if;
  logic [3:0] req_valid;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] req_ready;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_src;

  // Requester/consumer side
  modport master (
    output req_valid, d0, d1, d2, d3, out_ready,
    input  req_ready, sel, out_valid, out_data, out_src
  );

  // Arbiter side
  modport slave (
    input  req_valid, d0, d1, d2, d3, out_ready,
    output req_ready, sel, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_mux_4_feed.sv
// Round-robin arbiter over four 4-bit requesters feeding mux_4_1, with a
// single-entry registered output stage carrying the word and its source index.
module mux_4_1 (
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [1:0] sel,
  output logic [3:0] y
);
  always_comb begin
    y = d0;
    case (sel)
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = d0;
    endcase
  end
endmodule

module rr_mux_4_feed (
  input logic          clk,
  input logic          rst_n,
  rr_mux_4_feed_if.slave bus
);
  localparam int unsigned DW   = 4;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IW   = 2;

  logic [IW-1:0] last_q, last_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [IW-1:0] out_src_q, out_src_d;

  logic [IW-1:0] grant;
  logic [IW-1:0] idx;
  logic          any;
  logic          can_load;
  logic          accept;
  logic [DW-1:0] mux_y;

  // Scan from lowest to highest priority so the highest-priority hit wins
  always_comb begin
    grant = last_q;
    idx   = last_q;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last_q + IW'(k);
      if (bus.req_valid[idx]) grant = idx;
    end
  end

  assign any      = |bus.req_valid;
  assign can_load = !out_valid_q || bus.out_ready;
  // rst_n gates the combinational ready so nothing is accepted while in reset
  assign accept   = rst_n && can_load && any;

  assign bus.req_ready = accept ? (NREQ'(1) << grant) : '0;
  assign bus.sel       = accept ? grant : last_q;

  mux_4_1 u_mux (
    .d0  (bus.d0),
    .d1  (bus.d1),
    .d2  (bus.d2),
    .d3  (bus.d3),
    .sel (bus.sel),
    .y   (mux_y)
  );

  // Next-state: load on accept, drop valid on a drain with nothing to replace it
  always_comb begin
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (accept) begin
      last_d      = grant;
      out_valid_d = 1'b1;
      out_data_d  = mux_y;
      out_src_d   = grant;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= IW'(3);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_rr_mux_4_feed.sv
// Directed bench for rr_mux_4_feed: reset, rotation, backpressure, sparse
// requests, drain and X isolation on unselected inputs.
module tb_rr_mux_4_feed;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  rr_mux_4_feed_if bus ();

  rr_mux_4_feed dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = 4'hf;
    bus.d0 = 4'ha; bus.d1 = 4'hb; bus.d2 = 4'hc; bus.d3 = 4'hd;
    bus.out_ready = 1'b1;
    #2;
    n_vec++;
    if (bus.req_ready !== 4'b0000) begin
      n_err++; $display("FAIL rst_ready got=%b exp=0000", bus.req_ready);
    end
    n_vec++;
    if ({bus.out_valid, bus.out_data, bus.out_src} !== 7'd0) begin
      n_err++; $display("FAIL rst_state got v=%b d=%h s=%0d exp 0/0/0", bus.out_valid, bus.out_data, bus.out_src);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0001) begin
      n_err++; $display("FAIL rel_ready got=%b exp=0001", bus.req_ready);
    end
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'ha || bus.out_src !== 2'd0) begin
      n_err++; $display("FAIL first_load got v=%b d=%h s=%0d exp 1/a/0", bus.out_valid, bus.out_data, bus.out_src);
    end
    // Asynchronous reset while holding a word
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.out_valid, bus.out_data, bus.out_src} !== 7'd0) begin
      n_err++; $display("FAIL async_rst got v=%b d=%h s=%0d exp 0/0/0", bus.out_valid, bus.out_data, bus.out_src);
    end
    n_vec++;
    if (bus.req_ready !== 4'b0000) begin
      n_err++; $display("FAIL async_rst_ready got=%b exp=0000", bus.req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0001 || bus.sel !== 2'd0) begin
      n_err++; $display("FAIL rel2 got ready=%b sel=%0d exp 0001/0", bus.req_ready, bus.sel);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] vals [4];
    logic [3:0] exp_rdy;
    vals[0] = 4'ha; vals[1] = 4'hb; vals[2] = 4'hc; vals[3] = 4'hd;
    bus.req_valid = 4'hf;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_rdy = 4'b0001 << (i % 4);
      n_vec++;
      if (bus.req_ready !== exp_rdy || bus.sel !== 2'(i % 4)) begin
        n_err++; $display("FAIL rot_ready[%0d] got=%b sel=%0d exp=%b", i, bus.req_ready, bus.sel, exp_rdy);
      end
      tick();
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== vals[i % 4] || bus.out_src !== 2'(i % 4)) begin
        n_err++; $display("FAIL rot_out[%0d] got v=%b d=%h s=%0d exp 1/%h/%0d", i, bus.out_valid, bus.out_data, bus.out_src, vals[i % 4], i % 4);
      end
    end
  endtask

  task automatic test_backpressure();
    // last=0 here; one more accept puts b in the register
    n_vec++;
    if (bus.req_ready !== 4'b0010) begin
      n_err++; $display("FAIL bp_pre got=%b exp=0010", bus.req_ready);
    end
    tick();
    bus.out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (bus.req_ready !== 4'b0000) begin
        n_err++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, bus.req_ready);
      end
      tick();
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hb || bus.out_src !== 2'd1) begin
        n_err++; $display("FAIL bp_hold[%0d] got v=%b d=%h s=%0d exp 1/b/1", i, bus.out_valid, bus.out_data, bus.out_src);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0100) begin
      n_err++; $display("FAIL bp_resume got=%b exp=0100", bus.req_ready);
    end
    tick();
    n_vec++;
    if (bus.out_data !== 4'hc || bus.out_src !== 2'd2 || bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_after got d=%h s=%0d v=%b exp c/2/1", bus.out_data, bus.out_src, bus.out_valid);
    end
  endtask

  task automatic test_sparse_wrap();
    logic [1:0] exp_g [3];
    exp_g[0] = 2'd1; exp_g[1] = 2'd2; exp_g[2] = 2'd1;
    bus.req_valid = 4'b0100;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (bus.req_ready !== 4'b0100) begin
        n_err++; $display("FAIL sparse_ready[%0d] got=%b exp=0100", i, bus.req_ready);
      end
      tick();
      n_vec++;
      if (bus.out_src !== 2'd2 || bus.out_data !== 4'hc) begin
        n_err++; $display("FAIL sparse_out[%0d] got s=%0d d=%h exp 2/c", i, bus.out_src, bus.out_data);
      end
    end
    bus.req_valid = 4'b0110;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (bus.req_ready !== (4'b0001 << exp_g[i])) begin
        n_err++; $display("FAIL wrap_ready[%0d] got=%b exp_grant=%0d", i, bus.req_ready, exp_g[i]);
      end
      tick();
      n_vec++;
      if (bus.out_src !== exp_g[i]) begin
        n_err++; $display("FAIL wrap_src[%0d] got=%0d exp=%0d", i, bus.out_src, exp_g[i]);
      end
    end
  endtask

  task automatic test_drain();
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0000 || bus.sel !== 2'd1) begin
      n_err++; $display("FAIL drain_pre got ready=%b sel=%0d exp 0000/1", bus.req_ready, bus.sel);
    end
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'hb || bus.out_src !== 2'd1) begin
      n_err++; $display("FAIL drain got v=%b d=%h s=%0d exp 0/b/1", bus.out_valid, bus.out_data, bus.out_src);
    end
    n_vec++;
    if (bus.sel !== 2'd1) begin
      n_err++; $display("FAIL drain_last got sel=%0d exp=1", bus.sel);
    end
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'hb) begin
      n_err++; $display("FAIL idle got v=%b d=%h exp 0/b", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_x_isolation();
    logic [3:0] exp_d [3];
    logic [1:0] exp_s [3];
    exp_d[0] = 4'd3; exp_d[1] = 4'd7; exp_d[2] = 4'd10;
    exp_s[0] = 2'd2; exp_s[1] = 2'd0; exp_s[2] = 2'd1;
    bus.d0 = 4'd7; bus.d1 = 4'd10; bus.d2 = 4'd3; bus.d3 = 4'bxxxx;
    bus.req_valid = 4'b0111;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (bus.out_data !== exp_d[i] || bus.out_src !== exp_s[i] || bus.out_valid !== 1'b1) begin
        n_err++; $display("FAIL xiso[%0d] got d=%h s=%0d v=%b exp %h/%0d/1", i, bus.out_data, bus.out_src, bus.out_valid, exp_d[i], exp_s[i]);
      end
    end
    bus.d3 = 4'h5;
    bus.req_valid = 4'b1000;
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b1000) begin
      n_err++; $display("FAIL solo3_ready got=%b exp=1000", bus.req_ready);
    end
    tick();
    n_vec++;
    if (bus.out_data !== 4'h5 || bus.out_src !== 2'd3) begin
      n_err++; $display("FAIL solo3_out got d=%h s=%0d exp 5/3", bus.out_data, bus.out_src);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_rotation();
    test_backpressure();
    test_sparse_wrap();
    test_drain();
    test_x_isolation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
